// File: rtl/timer_pkg.sv
// Shared definitions for the player's elapsed/remaining time counters.
// Provides the 2-bit FSM encoding, per-digit limits and a helper that
// checks an M:SS digit triple for range.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [5:0] MAX_S0      = 6'd9;
   localparam logic [5:0] MAX_S1      = 6'd5;
   localparam logic [5:0] MAX_M0      = 6'd9;
   localparam logic [9:0] MAX_SECONDS = 10'd599;

   // True when every digit of an M:SS value is within its decimal range.
   function automatic logic mss_valid(input logic [5:0] m0,
                                      input logic [5:0] s1,
                                      input logic [5:0] s0);
      return (m0 <= MAX_M0) && (s1 <= MAX_S1) && (s0 <= MAX_S0);
   endfunction

endpackage

// File: rtl/sec_to_mss.sv
// Combinational converter: seconds count (0-599) to M:SS display digits.
// Ports:
//   seconds  in  10  seconds value
//   minutes0 out 6   seconds / 60
//   seconds1 out 6   (seconds % 60) / 10
//   seconds0 out 6   seconds % 10
// Inputs above 599 are not expected; the upper digit bits stay zero for
// any value in range.
module sec_to_mss (
   input  logic [9:0] seconds,
   output logic [5:0] minutes0,
   output logic [5:0] seconds1,
   output logic [5:0] seconds0
);

   logic [9:0] sec_in_min;

   assign sec_in_min = seconds % 10'd60;
   assign minutes0   = 6'(seconds / 10'd60);
   assign seconds1   = 6'(sec_in_min / 10'd10);
   assign seconds0   = 6'(seconds % 10'd10);

endmodule

// File: rtl/track_countdown_timer.sv
// Track countdown timer: loads a track length as M:SS, counts down once
// per CLK_DIV cycles while playing, applies forward seeks and flags the
// end of the track.
// Ports:
//   clk, reset (async, active low)
//   load + load_minutes0/load_seconds1/load_seconds0 : load a new length
//   count        : 1 = play, 0 = pause
//   skip + skip_amount : forward seek in seconds (0-63)
//   minutes0/seconds1/seconds0 : registered remaining-time digits
//   running / done : decoded from the FSM state (RUN / DONE)
//   load_err     : one-cycle pulse for a rejected load
module track_countdown_timer
   import timer_pkg::*;
#(
   parameter int CLK_DIV = 50_000_000,
   parameter int DIV_W   = 26
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [5:0] load_minutes0,
   input  logic [5:0] load_seconds1,
   input  logic [5:0] load_seconds0,
   input  logic       count,
   input  logic       skip,
   input  logic [5:0] skip_amount,
   output logic [5:0] minutes0,
   output logic [5:0] seconds1,
   output logic [5:0] seconds0,
   output logic       running,
   output logic       done,
   output logic       load_err
);

   state_t           state, state_nxt;
   logic [9:0]       rem, rem_nxt;
   logic [DIV_W-1:0] div, div_nxt;
   logic             err_nxt;

   logic             load_ok;
   logic [9:0]       load_val;
   logic [9:0]       skip_val;
   logic             advance;
   logic             wrap;
   logic [5:0]       dig_m0, dig_s1, dig_s0;

   assign load_ok  = mss_valid(load_minutes0, load_seconds1, load_seconds0);
   assign load_val = {4'd0, load_minutes0} * 10'd60
                   + {4'd0, load_seconds1} * 10'd10
                   + {4'd0, load_seconds0};
   assign skip_val = {4'd0, skip_amount};

   // The prescaler only moves while actually playing; dropping count in RUN
   // freezes it so a resume continues the partial second.
   assign advance = (state == RUN) && count;
   assign wrap    = advance && (div == DIV_W'(CLK_DIV - 1));

   always_comb begin
      state_nxt = state;
      rem_nxt   = rem;
      div_nxt   = div;
      err_nxt   = 1'b0;

      if (advance)
         div_nxt = wrap ? '0 : div + DIV_W'(1);

      case (state)
         RUN:     if (!count) state_nxt = PAUSE;
         PAUSE:   if (count)  state_nxt = RUN;
         default: ;
      endcase

      if (load) begin
         if (load_ok) begin
            rem_nxt   = load_val;
            div_nxt   = '0;
            state_nxt = (load_val == 10'd0) ? DONE : (count ? RUN : PAUSE);
         end else begin
            // A rejected load consumes the cycle: nothing else moves.
            rem_nxt   = rem;
            div_nxt   = div;
            state_nxt = state;
            err_nxt   = 1'b1;
         end
      end else if (skip && (state == RUN || state == PAUSE)) begin
         // Any tick in this cycle is dropped; div still follows advance.
         if (skip_val >= rem) begin
            rem_nxt   = 10'd0;
            state_nxt = DONE;
         end else begin
            rem_nxt = rem - skip_val;
         end
      end else if (wrap) begin
         rem_nxt = rem - 10'd1;
         if (rem == 10'd1)
            state_nxt = DONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         rem      <= 10'd0;
         div      <= '0;
         load_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         rem      <= rem_nxt;
         div      <= div_nxt;
         load_err <= err_nxt;
      end
   end

   sec_to_mss u_conv (
      .seconds  (rem),
      .minutes0 (dig_m0),
      .seconds1 (dig_s1),
      .seconds0 (dig_s0)
   );

   // Display digits trail rem by one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         minutes0 <= 6'd0;
         seconds1 <= 6'd0;
         seconds0 <= 6'd0;
      end else begin
         minutes0 <= dig_m0;
         seconds1 <= dig_s1;
         seconds0 <= dig_s0;
      end
   end

   assign running = (state == RUN);
   assign done    = (state == DONE);

endmodule

// File: tb/tb_track_countdown_timer.sv
module tb_track_countdown_timer;

   logic       clk = 1'b0;
   logic       reset;
   logic       load;
   logic [5:0] load_minutes0, load_seconds1, load_seconds0;
   logic       count;
   logic       skip;
   logic [5:0] skip_amount;
   logic [5:0] minutes0, seconds1, seconds0;
   logic       running, done, load_err;

   int tests  = 0;
   int failed = 0;

   track_countdown_timer #(.CLK_DIV(4), .DIV_W(3)) dut (
      .clk           (clk),
      .reset         (reset),
      .load          (load),
      .load_minutes0 (load_minutes0),
      .load_seconds1 (load_seconds1),
      .load_seconds0 (load_seconds0),
      .count         (count),
      .skip          (skip),
      .skip_amount   (skip_amount),
      .minutes0      (minutes0),
      .seconds1      (seconds1),
      .seconds0      (seconds0),
      .running       (running),
      .done          (done),
      .load_err      (load_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic ld;
      int   m, s1, s0;
      logic cnt;
      logic sk;
      int   amt;
      int   em, es1, es0;
      logic erun, edone, eerr;
   } vec_t;

   vec_t tbl[23];

   function automatic vec_t mk(logic ld, int m, int s1, int s0, logic cnt,
                               logic sk, int amt, int em, int es1, int es0,
                               logic erun, logic edone, logic eerr);
      vec_t v;
      v.ld = ld; v.m = m; v.s1 = s1; v.s0 = s0; v.cnt = cnt;
      v.sk = sk; v.amt = amt;
      v.em = em; v.es1 = es1; v.es0 = es0;
      v.erun = erun; v.edone = edone; v.eerr = eerr;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      tests++;
      if (got != exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   // Digits packed as m*10000 + s1*100 + s0 so each 6-bit digit is distinct.
   task automatic chk_dig(input string nm, input int m, input int s1, input int s0);
      chk(nm, int'(minutes0) * 10000 + int'(seconds1) * 100 + int'(seconds0),
          m * 10000 + s1 * 100 + s0);
   endtask

   task automatic do_load(input int m, input int s1, input int s0, input logic c);
      load          = 1'b1;
      load_minutes0 = 6'(m);
      load_seconds1 = 6'(s1);
      load_seconds0 = 6'(s0);
      count         = c;
      step();
      load          = 1'b0;
   endtask

   initial begin
      //            ld  m  s1 s0  cnt sk amt  em es1 es0 run done err
      tbl[0]  = mk(1, 0, 4, 0,  0, 0, 0,   0, 5, 9,  0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0,  0, 0, 0,   0, 4, 0,  0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0,  0, 1, 15,  0, 4, 0,  0, 0, 0);
      tbl[3]  = mk(0, 0, 0, 0,  0, 0, 0,   0, 2, 5,  0, 0, 0);
      tbl[4]  = mk(1, 1, 6, 0,  0, 0, 0,   0, 2, 5,  0, 0, 1);
      tbl[5]  = mk(0, 0, 0, 0,  0, 0, 0,   0, 2, 5,  0, 0, 0);
      tbl[6]  = mk(1, 0, 3, 12, 0, 0, 0,   0, 2, 5,  0, 0, 1);
      tbl[7]  = mk(1, 10, 0, 0, 0, 0, 0,   0, 2, 5,  0, 0, 1);
      tbl[8]  = mk(0, 0, 0, 0,  0, 1, 63,  0, 2, 5,  0, 1, 0);
      tbl[9]  = mk(0, 0, 0, 0,  0, 0, 0,   0, 0, 0,  0, 1, 0);
      tbl[10] = mk(0, 0, 0, 0,  0, 1, 5,   0, 0, 0,  0, 1, 0);
      tbl[11] = mk(1, 0, 7, 0,  0, 0, 0,   0, 0, 0,  0, 1, 1);
      tbl[12] = mk(1, 2, 1, 0,  0, 1, 5,   0, 0, 0,  0, 0, 0);
      tbl[13] = mk(0, 0, 0, 0,  0, 0, 0,   2, 1, 0,  0, 0, 0);
      tbl[14] = mk(0, 0, 0, 0,  0, 1, 0,   2, 1, 0,  0, 0, 0);
      tbl[15] = mk(0, 0, 0, 0,  0, 0, 0,   2, 1, 0,  0, 0, 0);
      tbl[16] = mk(0, 0, 0, 0,  0, 1, 63,  2, 1, 0,  0, 0, 0);
      tbl[17] = mk(0, 0, 0, 0,  0, 1, 63,  1, 0, 7,  0, 0, 0);
      tbl[18] = mk(0, 0, 0, 0,  0, 1, 4,   0, 0, 4,  0, 1, 0);
      tbl[19] = mk(0, 0, 0, 0,  0, 0, 0,   0, 0, 0,  0, 1, 0);
      tbl[20] = mk(1, 0, 0, 0,  0, 0, 0,   0, 0, 0,  0, 1, 0);
      tbl[21] = mk(1, 0, 0, 9,  1, 0, 0,   0, 0, 0,  1, 0, 0);
      tbl[22] = mk(0, 0, 0, 0,  1, 0, 0,   0, 0, 9,  1, 0, 0);

      reset = 1'b0;
      load = 1'b0; load_minutes0 = '0; load_seconds1 = '0; load_seconds0 = '0;
      count = 1'b0; skip = 1'b0; skip_amount = '0;

      // Reset state
      repeat (3) step();
      chk_dig("reset digits", 0, 0, 0);
      chk("reset running", int'(running), 0);
      chk("reset done", int'(done), 0);
      chk("reset load_err", int'(load_err), 0);
      reset = 1'b1;
      skip = 1'b1; skip_amount = 6'd5;
      step();
      skip = 1'b0;
      step();
      chk_dig("idle skip ignored", 0, 0, 0);
      chk("idle running", int'(running), 0);

      // 3:25 countdown with borrow across both digits
      do_load(3, 2, 5, 1);
      chk("A running", int'(running), 1);
      step();
      chk_dig("A 3:25", 3, 2, 5);
      repeat (3) step();
      chk_dig("A before first tick", 3, 2, 5);
      step();
      chk_dig("A 3:24", 3, 2, 4);
      repeat (96) step();
      chk_dig("A 3:00", 3, 0, 0);
      repeat (3) step();
      chk_dig("A 3:00 hold", 3, 0, 0);
      step();
      chk_dig("A 2:59", 2, 5, 9);

      // 0:02 runs out
      do_load(0, 0, 2, 1);
      repeat (5) step();
      chk_dig("B 0:01", 0, 0, 1);
      chk("B running", int'(running), 1);
      repeat (3) step();
      chk("B done", int'(done), 1);
      chk("B running off", int'(running), 0);
      step();
      chk_dig("B 0:00", 0, 0, 0);
      repeat (10) step();
      chk_dig("B stays 0:00", 0, 0, 0);
      chk("B done held", int'(done), 1);

      // Pause keeps the partial second
      do_load(1, 0, 0, 1);
      repeat (2) step();
      count = 1'b0;
      step();
      chk("C paused running", int'(running), 0);
      chk("C paused done", int'(done), 0);
      repeat (2) step();
      chk_dig("C hold 1:00", 1, 0, 0);
      count = 1'b1;
      step();
      chk("C resumed", int'(running), 1);
      step();
      chk_dig("C resume +1", 1, 0, 0);
      step();
      chk_dig("C resume +2", 1, 0, 0);
      step();
      chk_dig("C 0:59", 0, 5, 9);
      count = 1'b0;
      step();

      // Table: loads, skips, rejects, priorities
      foreach (tbl[i]) begin
         load          = tbl[i].ld;
         load_minutes0 = 6'(tbl[i].m);
         load_seconds1 = 6'(tbl[i].s1);
         load_seconds0 = 6'(tbl[i].s0);
         count         = tbl[i].cnt;
         skip          = tbl[i].sk;
         skip_amount   = 6'(tbl[i].amt);
         step();
         load = 1'b0;
         skip = 1'b0;
         chk_dig($sformatf("vec%0d digits", i), tbl[i].em, tbl[i].es1, tbl[i].es0);
         chk($sformatf("vec%0d running", i), int'(running), int'(tbl[i].erun));
         chk($sformatf("vec%0d done", i), int'(done), int'(tbl[i].edone));
         chk($sformatf("vec%0d load_err", i), int'(load_err), int'(tbl[i].eerr));
      end

      // Skip landing on the prescaler wrap drops that tick
      repeat (2) step();
      skip = 1'b1; skip_amount = 6'd2;
      step();
      skip = 1'b0;
      step();
      chk_dig("E 0:07", 0, 0, 7);
      repeat (3) step();
      chk_dig("E 0:07 hold", 0, 0, 7);
      step();
      chk_dig("E 0:06", 0, 0, 6);

      // Asynchronous reset between edges
      #3;
      reset = 1'b0;
      #1;
      chk_dig("F async digits", 0, 0, 0);
      chk("F async running", int'(running), 0);
      chk("F async done", int'(done), 0);
      step();
      reset = 1'b1;
      count = 1'b1;
      repeat (6) step();
      chk_dig("F after release", 0, 0, 0);
      chk("F idle running", int'(running), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
